// File: rtl/dbg_breakpoint_unit.sv
// Multi-slot breakpoint/watchpoint unit: byte-serial slot loading, fetch/read/write
// address matching, halt/step/resume control and hit reporting.
module dbg_breakpoint_unit #(
    parameter int unsigned NUM_BP = 4,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned CNT_W  = 8,
    localparam int unsigned SEL_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1,
    localparam int unsigned PTR_W = $clog2(ADDR_W / 8 + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_strobe,
    input  logic              ld_abort,
    input  logic [SEL_W-1:0]  ld_sel,
    input  logic [7:0]        ld_data,
    input  logic [ADDR_W-1:0] pc,
    input  logic              pc_valid,
    input  logic [ADDR_W-1:0] bus_a,
    input  logic              bus_rd,
    input  logic              bus_wr,
    input  logic              step,
    input  logic              resume,
    output logic              halt_req,
    output logic [SEL_W-1:0]  hit_id,
    output logic              hit_valid,
    output logic [CNT_W-1:0]  hit_count,
    output logic [PTR_W-1:0]  ld_ptr
);

    localparam int unsigned NB = ADDR_W / 8;

    typedef enum logic {StRun, StHalt} state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q [NUM_BP];
    logic [ADDR_W-1:0]  addr_d [NUM_BP];
    logic [3:0]         ctrl_q [NUM_BP];
    logic [3:0]         ctrl_d [NUM_BP];
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               armed_q, armed_d;
    logic [SEL_W-1:0]   hit_id_q, hit_id_d;
    logic               hit_valid_q, hit_valid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               any_match;
    logic [SEL_W-1:0]   win_id;

    // Descending scan so the lowest matching slot is the one left in win_id.
    always_comb begin
        any_match = 1'b0;
        win_id    = '0;
        for (int i = int'(NUM_BP) - 1; i >= 0; i--) begin
            if (ctrl_q[i][0] &&
                ((ctrl_q[i][1] && pc_valid && pc == addr_q[i]) ||
                 (ctrl_q[i][2] && bus_rd && bus_a == addr_q[i]) ||
                 (ctrl_q[i][3] && bus_wr && bus_a == addr_q[i]))) begin
                any_match = 1'b1;
                win_id    = SEL_W'(i);
            end
        end
    end

    always_comb begin
        addr_d = addr_q;
        ctrl_d = ctrl_q;
        ptr_d  = ptr_q;
        if (ld_abort) begin
            ptr_d = '0;
        end else if (ld_strobe) begin
            for (int s = 0; s < int'(NUM_BP); s++) begin
                if (32'(ld_sel) == 32'(s)) begin
                    for (int k = 0; k < int'(NB); k++) begin
                        if (ptr_q == PTR_W'(k)) addr_d[s][8*k +: 8] = ld_data;
                    end
                    if (ptr_q == PTR_W'(NB)) ctrl_d[s] = ld_data[3:0];
                end
            end
            ptr_d = (ptr_q == PTR_W'(NB)) ? '0 : ptr_q + 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        armed_d     = armed_q;
        hit_id_d    = hit_id_q;
        hit_valid_d = hit_valid_q;
        cnt_d       = cnt_q;
        unique case (state_q)
            StRun: begin
                if (any_match || (armed_q && pc_valid)) begin
                    state_d     = StHalt;
                    armed_d     = 1'b0;
                    hit_valid_d = any_match;
                    if (any_match) hit_id_d = win_id;
                    if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
                end
            end
            StHalt: begin
                if (resume) begin
                    state_d = StRun;
                    armed_d = 1'b0;
                end else if (step) begin
                    state_d = StRun;
                    armed_d = 1'b1;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StRun;
            ptr_q       <= '0;
            armed_q     <= 1'b0;
            hit_id_q    <= '0;
            hit_valid_q <= 1'b0;
            cnt_q       <= '0;
            for (int i = 0; i < int'(NUM_BP); i++) begin
                addr_q[i] <= '0;
                ctrl_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            armed_q     <= armed_d;
            hit_id_q    <= hit_id_d;
            hit_valid_q <= hit_valid_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            ctrl_q      <= ctrl_d;
        end
    end

    assign halt_req  = (state_q == StHalt);
    assign hit_id    = hit_id_q;
    assign hit_valid = hit_valid_q;
    assign hit_count = cnt_q;
    assign ld_ptr    = ptr_q;

endmodule

// File: tb/tb_dbg_breakpoint_unit.sv
// Directed bench for dbg_breakpoint_unit: a per-cycle reference model checked at every
// falling edge, plus literal expectations at key points of each scenario.
module tb_dbg_breakpoint_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld_strobe = 1'b0, ld_abort = 1'b0;
    logic [1:0]  ld_sel = '0;
    logic [7:0]  ld_data = '0;
    logic [15:0] pc = '0, bus_a = '0;
    logic        pc_valid = 1'b0, bus_rd = 1'b0, bus_wr = 1'b0;
    logic        step = 1'b0, resume = 1'b0;
    logic        halt_req, hit_valid;
    logic [1:0]  hit_id, ld_ptr;
    logic [7:0]  hit_count;

    int total = 0;
    int bad   = 0;

    dbg_breakpoint_unit dut (
        .clk(clk), .rst(rst), .ld_strobe(ld_strobe), .ld_abort(ld_abort),
        .ld_sel(ld_sel), .ld_data(ld_data), .pc(pc), .pc_valid(pc_valid),
        .bus_a(bus_a), .bus_rd(bus_rd), .bus_wr(bus_wr), .step(step), .resume(resume),
        .halt_req(halt_req), .hit_id(hit_id), .hit_valid(hit_valid),
        .hit_count(hit_count), .ld_ptr(ld_ptr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: slot table and halt bookkeeping in plain integers.
    int m_addr [4];
    int m_ctrl [4];
    int m_ptr, m_id, m_cnt;
    bit m_halt, m_armed, m_valid;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin m_addr[i] = 0; m_ctrl[i] = 0; end
            m_ptr = 0; m_id = 0; m_cnt = 0; m_halt = 0; m_armed = 0; m_valid = 0;
        end else begin
            int win;
            win = -1;
            for (int i = 0; i < 4; i++) begin
                bit en, hx, hr, hw;
                en = m_ctrl[i][0];
                hx = m_ctrl[i][1] && pc_valid && int'(pc) == m_addr[i];
                hr = m_ctrl[i][2] && bus_rd && int'(bus_a) == m_addr[i];
                hw = m_ctrl[i][3] && bus_wr && int'(bus_a) == m_addr[i];
                if (win < 0 && en && (hx || hr || hw)) win = i;
            end
            if (!m_halt) begin
                if (win >= 0 || (m_armed && pc_valid)) begin
                    m_halt  = 1;
                    m_armed = 0;
                    m_valid = (win >= 0);
                    if (win >= 0) m_id = win;
                    if (m_cnt < 255) m_cnt++;
                end
            end else if (resume) begin
                m_halt = 0; m_armed = 0;
            end else if (step) begin
                m_halt = 0; m_armed = 1;
            end
            if (ld_abort) m_ptr = 0;
            else if (ld_strobe) begin
                if (m_ptr < 2)
                    m_addr[ld_sel] = (m_addr[ld_sel] & ~(255 << (8 * m_ptr)))
                                   | (int'(ld_data) << (8 * m_ptr));
                else
                    m_ctrl[ld_sel] = int'(ld_data) & 15;
                m_ptr = (m_ptr == 2) ? 0 : m_ptr + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("halt_req", int'(halt_req), int'(m_halt));
            chk("hit_valid", int'(hit_valid), int'(m_valid));
            chk("hit_count", int'(hit_count), m_cnt);
            chk("ld_ptr", int'(ld_ptr), m_ptr);
            if (m_valid) chk("hit_id", int'(hit_id), m_id);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        ld_strobe = 0; ld_abort = 0; pc_valid = 0; bus_rd = 0; bus_wr = 0;
        step = 0; resume = 0;
    endtask

    task automatic strobe(input logic [1:0] sel, input logic [7:0] data);
        ld_sel = sel; ld_data = data; ld_strobe = 1;
        tick();
    endtask

    task automatic load3(input logic [1:0] sel, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2);
        strobe(sel, b0); strobe(sel, b1); strobe(sel, b2);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_halt", int'(halt_req), 0);
        chk("rst_count", int'(hit_count), 0);
        chk("rst_ptr", int'(ld_ptr), 0);
        chk("rst_valid", int'(hit_valid), 0);
        chk("rst_id", int'(hit_id), 0);
        rst = 0;

        // Exec breakpoint at 0x0150 in slot 0
        load3(2'd0, 8'h50, 8'h01, 8'h03);
        chk("t1_ptr", int'(ld_ptr), 0);
        pc = 16'h0150; pc_valid = 1; tick();
        chk("t1_halt", int'(halt_req), 1);
        chk("t1_id", int'(hit_id), 0);
        chk("t1_valid", int'(hit_valid), 1);
        chk("t1_count", int'(hit_count), 1);
        resume = 1; tick();
        chk("t1_resume", int'(halt_req), 0);

        // Two write watchpoints on the same address: lowest slot wins
        load3(2'd1, 8'h40, 8'hFF, 8'h09);
        load3(2'd2, 8'h40, 8'hFF, 8'h09);
        bus_a = 16'hFF40; bus_rd = 1; tick();
        chk("t2_rd_nohalt", int'(halt_req), 0);
        bus_wr = 1; tick();
        chk("t2_halt", int'(halt_req), 1);
        chk("t2_id", int'(hit_id), 1);
        chk("t2_count", int'(hit_count), 2);
        resume = 1; tick();
        chk("t2_resume", int'(halt_req), 0);

        // Step: the fetch in the step cycle is ignored, the next fetch re-halts
        bus_wr = 1; tick();
        chk("t3_halt", int'(halt_req), 1);
        step = 1; pc = 16'h0150; pc_valid = 1; tick();
        chk("t3_run", int'(halt_req), 0);
        pc = 16'h0200; pc_valid = 1; tick();
        chk("t3_rehalt", int'(halt_req), 1);
        chk("t3_valid", int'(hit_valid), 0);
        chk("t3_count", int'(hit_count), 4);

        // Abort mid-load (abort beats a same-cycle strobe), then reload slot 3
        strobe(2'd3, 8'hAA); strobe(2'd3, 8'hBB);
        chk("t4_ptr2", int'(ld_ptr), 2);
        ld_sel = 2'd3; ld_data = 8'h77; ld_strobe = 1; ld_abort = 1; tick();
        chk("t4_abort", int'(ld_ptr), 0);
        load3(2'd3, 8'h34, 8'h12, 8'h05);
        chk("t4_ptr0", int'(ld_ptr), 0);
        resume = 1; tick();
        bus_a = 16'h1234; bus_rd = 1; tick();
        chk("t4_halt", int'(halt_req), 1);
        chk("t4_id", int'(hit_id), 3);
        chk("t4_count", int'(hit_count), 5);

        // Step and resume together: resume wins, no step re-halt
        step = 1; resume = 1; tick();
        chk("t5_run", int'(halt_req), 0);
        pc = 16'h0200; pc_valid = 1; tick();
        chk("t5_nohalt", int'(halt_req), 0);
        resume = 1; step = 1; tick();
        chk("t5_run_noeffect", int'(halt_req), 0);

        // Saturate the hit counter
        for (int n = 0; n < 300; n++) begin
            pc = 16'h0150; pc_valid = 1; tick();
            resume = 1; tick();
        end
        chk("t6_sat", int'(hit_count), 255);

        // Asynchronous reset in the middle of a load
        strobe(2'd0, 8'h11);
        chk("t6_ptr1", int'(ld_ptr), 1);
        #2 rst = 1;
        #1;
        chk("t6_rst_ptr", int'(ld_ptr), 0);
        chk("t6_rst_count", int'(hit_count), 0);
        @(posedge clk);
        #1 rst = 0;
        pc = 16'h0150; pc_valid = 1; tick();
        chk("t6_x_off", int'(halt_req), 0);
        bus_a = 16'hFF40; bus_wr = 1; tick();
        chk("t6_w_off", int'(halt_req), 0);
        bus_a = 16'h1234; bus_rd = 1; tick();
        chk("t6_r_off", int'(halt_req), 0);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
